// File: rtl/triggered_timer_bank.sv
// triggered_timer_bank: bank of independent triggered down-counting timers with one-shot/periodic modes
module triggered_timer_bank #(
   parameter int NUM_CHANNELS = 4,
   parameter int COUNTER_BITS = 8,
   parameter bit RETRIGGER    = 1'b0
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 clk_en,
   input  logic                                 en,
   input  logic [NUM_CHANNELS*COUNTER_BITS-1:0] count,
   input  logic [NUM_CHANNELS-1:0]              trigger,
   input  logic [NUM_CHANNELS-1:0]              periodic,
   input  logic [NUM_CHANNELS-1:0]              abort,
   output logic [NUM_CHANNELS-1:0]              done,
   output logic [NUM_CHANNELS-1:0]              rdy,
   output logic [NUM_CHANNELS*COUNTER_BITS-1:0] remaining
);
   typedef enum logic {IDLE, RUN} state_t;
   localparam logic [COUNTER_BITS-1:0] ONE = COUNTER_BITS'(1);
   logic tick;
   assign tick = clk_en & en;
   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
      state_t st, st_n;
      logic [COUNTER_BITS-1:0] rem, rem_n, rld, rld_n, cnt;
      logic md, md_n, dn, dn_n;
      assign cnt = count[i*COUNTER_BITS +: COUNTER_BITS];
      assign done[i] = dn;
      assign rdy[i] = (st == IDLE);
      assign remaining[i*COUNTER_BITS +: COUNTER_BITS] = rem;
      // next state: abort beats trigger beats tick; expiry reloads in periodic mode, idles otherwise
      always_comb begin
         st_n  = st;
         rem_n = rem;
         rld_n = rld;
         md_n  = md;
         dn_n  = 1'b0;
         if (st == IDLE) begin
            if (trigger[i] && !abort[i]) begin
               st_n  = RUN;
               rem_n = cnt;
               rld_n = cnt;
               md_n  = periodic[i];
            end
         end else if (abort[i]) begin
            st_n  = IDLE;
            rem_n = '0;
         end else if (trigger[i] && RETRIGGER) begin
            rem_n = cnt;
            rld_n = cnt;
            md_n  = periodic[i];
         end else if (tick) begin
            if (rem > ONE) begin
               rem_n = rem - ONE;
            end else begin
               dn_n  = 1'b1;
               st_n  = md ? RUN : IDLE;
               rem_n = md ? rld : '0;
            end
         end
      end
      // channel registers, cleared asynchronously
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            st  <= IDLE;
            rem <= '0;
            rld <= '0;
            md  <= 1'b0;
            dn  <= 1'b0;
         end else begin
            st  <= st_n;
            rem <= rem_n;
            rld <= rld_n;
            md  <= md_n;
            dn  <= dn_n;
         end
      end
   end
endmodule

// File: tb/tb_triggered_timer_bank.sv
// tb_triggered_timer_bank: directed checks of the timer bank, RETRIGGER=0 and RETRIGGER=1 instances
module tb_triggered_timer_bank;
   logic clk = 1'b0, reset = 1'b1, clk_en = 1'b0, en = 1'b1;
   logic [31:0] count = '0;
   logic [3:0] trigger = '0, periodic = '0, abort = '0;
   logic [3:0] done, rdy, done_r, rdy_r;
   logic [31:0] remaining, remaining_r;
   int errs = 0, checks = 0;
   int fd0[4], fd1[4], nd0[4], nd1[4], dslot[8];
   logic [3:0] tb_per = '0;

   triggered_timer_bank #(.NUM_CHANNELS(4), .COUNTER_BITS(8), .RETRIGGER(1'b0)) dut (
      .clk(clk), .reset(reset), .clk_en(clk_en), .en(en), .count(count), .trigger(trigger),
      .periodic(periodic), .abort(abort), .done(done), .rdy(rdy), .remaining(remaining));
   triggered_timer_bank #(.NUM_CHANNELS(4), .COUNTER_BITS(8), .RETRIGGER(1'b1)) dut_r (
      .clk(clk), .reset(reset), .clk_en(clk_en), .en(en), .count(count), .trigger(trigger),
      .periodic(periodic), .abort(abort), .done(done_r), .rdy(rdy_r), .remaining(remaining_r));

   always #5 clk = ~clk;

   task automatic trig(input logic [3:0] m, input logic [31:0] cnts, input logic [3:0] per);
      trigger = m;
      count = cnts;
      periodic = per;
      clk_en = 1'b0;
      for (int k = 0; k < 4; k++) if (m[k]) tb_per[k] = per[k];
      @(posedge clk);
      #1;
      trigger = '0;
   endtask

   // slots = clk_en pulses since start; en is low for slots in [ff, ff+fl)
   task automatic measure(input int div, input int cyc, input int ch, input int ff, input int fl);
      int s = 0;
      for (int k = 0; k < 4; k++) begin fd0[k] = -1; fd1[k] = -1; nd0[k] = 0; nd1[k] = 0; end
      for (int c = 0; c < cyc; c++) begin
         clk_en = ((c % div) == div - 1);
         if (clk_en) s++;
         en = !(s >= ff && s < ff + fl);
         @(posedge clk);
         #1;
         for (int k = 0; k < 4; k++) begin
            if (done[k]) begin
               if (fd0[k] < 0) fd0[k] = s;
               if (k == ch && nd0[k] < 8) dslot[nd0[k]] = s;
               nd0[k]++;
               if (!tb_per[k]) begin
                  checks++;
                  if (rdy[k] !== 1'b1) begin errs++; $display("FAIL rdy_with_done ch%0d got=%b want=1", k, rdy[k]); end
               end
            end
            if (done_r[k]) begin
               if (fd1[k] < 0) fd1[k] = s;
               nd1[k]++;
            end
         end
      end
      clk_en = 1'b0;
      en = 1'b1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      trigger = 4'hf;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({rdy, rdy_r} !== 8'hff) begin errs++; $display("FAIL reset_rdy got=%h want=ff", {rdy, rdy_r}); end
      checks++;
      if ({done, done_r} !== 8'h00) begin errs++; $display("FAIL reset_done got=%h want=00", {done, done_r}); end
      checks++;
      if ({remaining, remaining_r} !== 64'h0) begin errs++; $display("FAIL reset_remaining got=%h want=0", {remaining, remaining_r}); end
      trigger = '0;
      reset = 1'b0;
      measure(1, 8, 0, 0, 0);
      checks++;
      if (nd0[0] + nd0[1] + nd0[2] + nd0[3] + nd1[0] + nd1[1] + nd1[2] + nd1[3] !== 0) begin
         errs++; $display("FAIL reset_spurious_done got=%0d want=0", nd0[0] + nd0[1] + nd0[2] + nd0[3]);
      end
   endtask

   task automatic test_oneshot;
      trig(4'b0001, 32'h0000_0003, 4'b0000);
      checks++;
      if (rdy[0] !== 1'b0 || remaining[7:0] !== 8'd3) begin
         errs++; $display("FAIL oneshot_load rdy=%b rem=%0d want rdy=0 rem=3", rdy[0], remaining[7:0]);
      end
      measure(2, 20, 0, 0, 0);
      checks++;
      if (fd0[0] !== 3 || nd0[0] !== 1) begin errs++; $display("FAIL oneshot_done slot=%0d n=%0d want slot=3 n=1", fd0[0], nd0[0]); end
      trig(4'b0001, 32'h0000_0003, 4'b0000);
      measure(2, 20, 0, 1, 1000);
      checks++;
      if (nd0[0] !== 0 || remaining[7:0] !== 8'd3) begin errs++; $display("FAIL en_low_frozen n=%0d rem=%0d want n=0 rem=3", nd0[0], remaining[7:0]); end
      abort = 4'b0001;
      @(posedge clk);
      #1;
      abort = '0;
      checks++;
      if (rdy[0] !== 1'b1 || remaining[7:0] !== 8'd0) begin errs++; $display("FAIL abort_ch0 rdy=%b rem=%0d want rdy=1 rem=0", rdy[0], remaining[7:0]); end
   endtask

   task automatic test_count0_and_freeze;
      trig(4'b0010, 32'h0000_0000, 4'b0000);
      measure(2, 10, 1, 0, 0);
      checks++;
      if (fd0[1] !== 1 || nd0[1] !== 1) begin errs++; $display("FAIL count0_done slot=%0d n=%0d want slot=1 n=1", fd0[1], nd0[1]); end
      trig(4'b0010, 32'h0000_0500, 4'b0000);
      measure(2, 24, 1, 3, 2);
      checks++;
      if (fd0[1] !== 7 || nd0[1] !== 1) begin errs++; $display("FAIL freeze_done slot=%0d n=%0d want slot=7 n=1", fd0[1], nd0[1]); end
   endtask

   task automatic test_periodic;
      trig(4'b0100, 32'h0004_0000, 4'b0100);
      measure(1, 21, 2, 0, 0);
      checks++;
      if (nd0[2] !== 5) begin errs++; $display("FAIL periodic_count got=%0d want=5", nd0[2]); end
      for (int j = 0; j < 5; j++) begin
         checks++;
         if (dslot[j] !== 4 * (j + 1)) begin errs++; $display("FAIL periodic_slot%0d got=%0d want=%0d", j, dslot[j], 4 * (j + 1)); end
      end
      checks++;
      if (rdy[2] !== 1'b0) begin errs++; $display("FAIL periodic_running rdy=%b want=0", rdy[2]); end
      abort = 4'b0100;
      @(posedge clk);
      #1;
      abort = '0;
      checks++;
      if (rdy[2] !== 1'b1 || remaining[23:16] !== 8'd0) begin errs++; $display("FAIL periodic_abort rdy=%b rem=%0d want rdy=1 rem=0", rdy[2], remaining[23:16]); end
      measure(1, 12, 2, 0, 0);
      checks++;
      if (nd0[2] !== 0 || nd1[2] !== 0) begin errs++; $display("FAIL periodic_after_abort n=%0d want=0", nd0[2]); end
   endtask

   task automatic test_retrigger;
      trig(4'b1000, 32'h0500_0000, 4'b0000);
      measure(2, 6, 3, 0, 0);
      checks++;
      if (remaining[31:24] !== 8'd2 || remaining_r[31:24] !== 8'd2) begin
         errs++; $display("FAIL retrig_pre rem=%0d/%0d want=2/2", remaining[31:24], remaining_r[31:24]);
      end
      trig(4'b1000, 32'h0500_0000, 4'b0000);
      checks++;
      if (remaining[31:24] !== 8'd2 || remaining_r[31:24] !== 8'd5) begin
         errs++; $display("FAIL retrig_load rem=%0d/%0d want=2/5", remaining[31:24], remaining_r[31:24]);
      end
      measure(2, 14, 3, 0, 0);
      checks++;
      if (fd0[3] !== 2 || nd0[3] !== 1) begin errs++; $display("FAIL retrig_off_done slot=%0d n=%0d want slot=2 n=1", fd0[3], nd0[3]); end
      checks++;
      if (fd1[3] !== 5 || nd1[3] !== 1) begin errs++; $display("FAIL retrig_on_done slot=%0d n=%0d want slot=5 n=1", fd1[3], nd1[3]); end
   endtask

   task automatic test_concurrency;
      trig(4'b1111, 32'h0403_0201, 4'b0000);
      checks++;
      if (rdy !== 4'b0000 || remaining !== 32'h0403_0201) begin errs++; $display("FAIL conc_load rdy=%b rem=%h want rdy=0000 rem=04030201", rdy, remaining); end
      measure(1, 8, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (fd0[k] !== k + 1 || nd0[k] !== 1) begin errs++; $display("FAIL conc_ch%0d slot=%0d n=%0d want slot=%0d n=1", k, fd0[k], nd0[k], k + 1); end
      end
   endtask

   task automatic test_priority;
      trigger = 4'b0001;
      abort = 4'b0001;
      count = 32'h0000_0005;
      @(posedge clk);
      #1;
      trigger = '0;
      abort = '0;
      checks++;
      if (rdy[0] !== 1'b1 || remaining[7:0] !== 8'd0) begin errs++; $display("FAIL abort_trigger_idle rdy=%b rem=%0d want rdy=1 rem=0", rdy[0], remaining[7:0]); end
      trig(4'b1111, 32'h0a0a_0a0a, 4'b0101);
      measure(1, 3, 0, 0, 0);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (rdy !== 4'hf || rdy_r !== 4'hf || remaining !== 32'h0 || done !== 4'h0) begin
         errs++; $display("FAIL reset_midrun rdy=%b rem=%h done=%b want rdy=1111 rem=0 done=0", rdy, remaining, done);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      measure(1, 15, 0, 0, 0);
      checks++;
      if (nd0[0] + nd0[1] + nd0[2] + nd0[3] !== 0 || rdy !== 4'hf) begin
         errs++; $display("FAIL after_reset_done n=%0d rdy=%b want n=0 rdy=1111", nd0[0] + nd0[1] + nd0[2] + nd0[3], rdy);
      end
   endtask

   initial begin
      test_reset;
      test_oneshot;
      test_count0_and_freeze;
      test_periodic;
      test_retrigger;
      test_concurrency;
      test_priority;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/triggered_timer_bank.md
# triggered_timer_bank

Parametrised bank of independent triggered down-counting timers, the next generation of the single-channel triggered timer used by the plotter's motor and servo sequencing logic. Each channel loads a tick count on a trigger, counts down on the shared `clk_en` tick while `en` is high, and pulses `done` on expiry. Beyond the single-channel block, it adds per-channel one-shot or periodic mode, abort, optional retrigger and a live remaining-count readout. It sits between the command sequencer and the step/PWM generators and is driven by a shared `FreqDivider` tick.

## Interface
- `NUM_CHANNELS`, default 4: number of independent timer channels (≥1).
- `COUNTER_BITS`, default `BYTE_BITS` (8): width of each channel's count.
- `RETRIGGER`, default 0: 1 means a trigger on a running channel reloads it; 0 means such a trigger is ignored.
- `clk`  in  1: system clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `clk_en`  in  1: shared tick strobe, one `clk` cycle wide.
- `en`  in  1: global count enable; low freezes every running channel.
- `count`  in  NUM_CHANNELS*COUNTER_BITS: per-channel load value; channel i uses bits [i*COUNTER_BITS +: COUNTER_BITS].
- `trigger`  in  NUM_CHANNELS: per-channel start request, level-sampled each `clk` edge.
- `periodic`  in  NUM_CHANNELS: per-channel mode, latched at trigger (1 = periodic, 0 = one-shot).
- `abort`  in  NUM_CHANNELS: per-channel stop request.
- `done`  out  NUM_CHANNELS: one-`clk`-cycle expiry pulse per channel.
- `rdy`  out  NUM_CHANNELS: channel is IDLE and will accept a trigger.
- `remaining`  out  NUM_CHANNELS*COUNTER_BITS: current down-counter value per channel.

## Operation
- Per channel, two states: IDLE and RUN. Channel registers: `rem`, `reload` (latched `count`), `mode` (latched `periodic`).
- Reset, asynchronous: every channel goes to IDLE with `rem`=0, `reload`=0, `mode`=0, `done`=0 and `rdy`=1.
- IDLE with `trigger`: load `rem`=`reload`=count_i and `mode`=periodic_i, then go to RUN. Triggers are accepted regardless of `clk_en` and `en`.
- In RUN, a count tick is a cycle with `clk_en`=1 and `en`=1. Other cycles hold `rem`.
- On a tick, if `rem` > 1, `rem` decrements by 1. If `rem` ≤ 1, the channel expires, so a count of 0 or 1 expires on the first tick.
- Expiry in one-shot mode: go to IDLE, set `rem`=0, pulse `done`.
- Expiry in periodic mode: reload `rem`=`reload`, stay in RUN, pulse `done`. This repeats until abort.
- In RUN with `abort`: go to IDLE and set `rem`=0 with no `done`. Abort in IDLE has no effect.
- Priority per channel: abort > trigger > tick.
  - Abort together with trigger in IDLE: the channel stays IDLE.
  - With RETRIGGER=1, a trigger in RUN reloads `rem`, `reload` and `mode`. If the same cycle is an expiring tick, the trigger wins and there is no `done`.
  - With RETRIGGER=0, a trigger in RUN is ignored and an expiring tick proceeds normally.
- Channels are fully independent apart from the shared `clk_en` and `en`.
- No arithmetic wrap: `rem` never decrements below 1 before expiry.

## Timing
- `done`, `rdy` and `remaining` are registered outputs.
- Trigger sampled at edge T0 moves the channel to RUN: `rdy` falls after T0 and `remaining` shows count_i after T0.
- With `clk_en` and `en` high every cycle and count=N≥1, ticks occur at edges T1..TN. `done` is high for exactly the cycle following edge TN.
- With count=0, expiry happens at T1.
- In one-shot mode, `rdy` rises in the same cycle as `done`, so a trigger held high restarts the channel on the very next edge.
- With `clk_en` every 2 cycles, expiry occurs on the N-th tick after the trigger.
- `done` is never high for more than one cycle per expiry.
- Periodic mode: consecutive `done` pulses are exactly `reload` ticks apart (1 tick if `reload` ≤ 1).
- `en` low in RUN freezes the channel: ticks are lost, not queued, and `done` is delayed by the number of frozen ticks.
- Reset asserted mid-RUN clears everything immediately with no `done`. After reset deasserts, the first edge may accept a trigger.

## Test plan
- Reset: hold reset with `trigger`=all-ones. All `rdy`=1, `done`=0 and `remaining`=0 during reset, with no spurious `done` after release.
- One-shot, `clk_en` divide-by-2, `en`=1, ch0 count=3: `done[0]` pulses once, 3 ticks (6 `clk`) after the trigger, and `rdy[0]` returns high alongside it. With `en`=0 held, there is never a `done`.
- Count=0 on ch1: `done[1]` on the first tick. Count=5 with `en` dropped for 2 ticks mid-run: `done` arrives 7 ticks after the trigger.
- Periodic ch2 with count=4: `done[2]` every 4 ticks, five pulses observed. Abort then gives `rdy[2]`=1, `remaining`=0 and no further `done`.
- Retrigger: with RETRIGGER=1, count=5 and a retrigger at remaining=2, `done` comes 5 ticks after the retrigger. With RETRIGGER=0, the same stimulus gives `done` on the original schedule.
- Concurrency and priority: all four channels triggered with counts 1, 2, 3, 4 give staggered single `done` pulses. Abort+trigger together leaves the channel IDLE, and reset asserted mid-run clears all channels.
